// File: rtl/wrr_pkg.sv
// Shared channel codes, channel count and FSM states for the weighted round-robin scheduler.
package wrr_pkg;

  localparam int NUM_VCH = 4;

  localparam logic [1:0] VCHANEL0 = 2'b00;
  localparam logic [1:0] VCHANEL1 = 2'b01;
  localparam logic [1:0] VCHANEL2 = 2'b10;
  localparam logic [1:0] VCHANEL3 = 2'b11;

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } state_t;

endpackage

// File: rtl/wrr_next_channel.sv
// Rotating-priority search: first eligible channel in order cur+1, cur+2, cur+3, cur.
// Purely combinational, no backpressure.
module wrr_next_channel
  import wrr_pkg::*;
(
  input  logic [1:0]         cur,
  input  logic [NUM_VCH-1:0] elig,
  output logic               found,
  output logic [1:0]         idx
);

  logic [1:0] cand;

  // Walk from the lowest priority down so the highest-priority hit is the last write.
  always_comb begin
    found = 1'b0;
    idx   = cur;
    cand  = cur;
    for (int k = NUM_VCH; k >= 1; k--) begin
      cand = cur + 2'(k);
      if (elig[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/wrr_scheduler.sv
// Weighted round-robin VC scheduler: combinational pop, select/valid registered one cycle later.
// enb or ready_in low suppresses pops and freezes all scheduling state.
module wrr_scheduler
  import wrr_pkg::*;
#(
  parameter int WEIGHT_WIDTH = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enb,
  input  logic                    ready_in,
  input  logic                    empty_vchanel0,
  input  logic                    empty_vchanel1,
  input  logic                    empty_vchanel2,
  input  logic                    empty_vchanel3,
  input  logic [WEIGHT_WIDTH-1:0] weight0,
  input  logic [WEIGHT_WIDTH-1:0] weight1,
  input  logic [WEIGHT_WIDTH-1:0] weight2,
  input  logic [WEIGHT_WIDTH-1:0] weight3,
  output logic                    pop_vchanel0,
  output logic                    pop_vchanel1,
  output logic                    pop_vchanel2,
  output logic                    pop_vchanel3,
  output logic [1:0]              arbiter,
  output logic                    valid_out
);

  logic [NUM_VCH-1:0]      empty, elig, pop;
  logic [WEIGHT_WIDTH-1:0] weight [NUM_VCH];
  logic [WEIGHT_WIDTH-1:0] credit, burst_w;
  logic [1:0]              cur, g, nxt_idx;
  logic                    nxt_found, go, cont, take, grant;
  state_t                  state;

  assign empty = {empty_vchanel3, empty_vchanel2, empty_vchanel1, empty_vchanel0};
  assign weight[0] = weight0;
  assign weight[1] = weight1;
  assign weight[2] = weight2;
  assign weight[3] = weight3;

  always_comb begin
    for (int n = 0; n < NUM_VCH; n++) begin
      elig[n] = ~empty[n] & (|weight[n]);
    end
  end

  wrr_next_channel u_next (
    .cur   (cur),
    .elig  (elig),
    .found (nxt_found),
    .idx   (nxt_idx)
  );

  assign go    = enb & ready_in;
  assign cont  = (state == SERVE) & elig[cur] & (credit < burst_w);
  assign take  = cont | nxt_found;
  assign g     = cont ? cur : nxt_idx;
  // Gated by rst so pops drop the instant reset asserts, before any edge.
  assign grant = go & take & rst;

  always_comb begin
    pop = '0;
    if (grant) pop[g] = 1'b1;
  end

  assign {pop_vchanel3, pop_vchanel2, pop_vchanel1, pop_vchanel0} = pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cur       <= VCHANEL3;
      credit    <= '0;
      burst_w   <= '0;
      arbiter   <= VCHANEL0;
      valid_out <= 1'b0;
    end else if (go && take) begin
      state     <= SERVE;
      arbiter   <= g;
      valid_out <= 1'b1;
      if (cont) begin
        credit <= credit + 1'b1;
      end else begin
        cur     <= nxt_idx;
        credit  <= WEIGHT_WIDTH'(1);
        burst_w <= weight[nxt_idx];
      end
    end else if (go) begin
      state     <= IDLE;
      credit    <= '0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wrr_scheduler.sv
// Self-checking bench: per-cycle comparison against a quota-based model, directed literal sequences, random soak.
module tb_wrr_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enb = 1'b1;
  logic       ready_in = 1'b1;
  logic [3:0] empty = 4'hF;
  logic [2:0] w [4];
  logic       pop0, pop1, pop2, pop3;
  logic [1:0] arbiter;
  logic       valid_out;

  int checks = 0;
  int errors = 0;
  int log_q[$];

  // Model: current channel, whether a burst is running, grants left in it.
  int m_cur = 3;
  bit m_serving = 1'b0;
  int m_left = 0;
  int m_arb = 0;
  bit m_vld = 1'b0;

  bit   u_f, u_c, n_f, n_c;
  int   u_g, n_g;
  logic [3:0] pv, exp_pop;
  int   exp_arb;
  bit   exp_vld;

  always #5 clk = ~clk;

  wrr_scheduler #(.WEIGHT_WIDTH(3)) dut (
    .clk            (clk),
    .rst            (rst),
    .enb            (enb),
    .ready_in       (ready_in),
    .empty_vchanel0 (empty[0]),
    .empty_vchanel1 (empty[1]),
    .empty_vchanel2 (empty[2]),
    .empty_vchanel3 (empty[3]),
    .weight0        (w[0]),
    .weight1        (w[1]),
    .weight2        (w[2]),
    .weight3        (w[3]),
    .pop_vchanel0   (pop0),
    .pop_vchanel1   (pop1),
    .pop_vchanel2   (pop2),
    .pop_vchanel3   (pop3),
    .arbiter        (arbiter),
    .valid_out      (valid_out)
  );

  function automatic bit ch_ok(int n);
    return (empty[n] == 1'b0) && (w[n] != 3'd0);
  endfunction

  function automatic void decide(output bit f, output int g, output bit c);
    f = 1'b0; g = 0; c = 1'b0;
    if (!(enb && ready_in)) return;
    if (m_serving && ch_ok(m_cur) && m_left > 0) begin
      f = 1'b1; g = m_cur; c = 1'b1;
      return;
    end
    for (int k = 1; k <= 4; k++) begin
      int n;
      n = (m_cur + k) % 4;
      if (ch_ok(n)) begin
        f = 1'b1; g = n;
        return;
      end
    end
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      m_cur = 3; m_serving = 1'b0; m_left = 0; m_arb = 0; m_vld = 1'b0;
    end else begin
      decide(u_f, u_g, u_c);
      if (u_f) begin
        if (u_c) m_left = m_left - 1;
        else begin
          m_cur = u_g; m_left = int'(w[u_g]) - 1; m_serving = 1'b1;
        end
        m_arb = u_g; m_vld = 1'b1;
      end else begin
        m_vld = 1'b0;
        if (enb && ready_in) begin
          m_serving = 1'b0; m_left = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    pv = {pop3, pop2, pop1, pop0};
    if (!rst) begin
      exp_pop = 4'b0; exp_arb = 0; exp_vld = 1'b0;
    end else begin
      decide(n_f, n_g, n_c);
      exp_pop = 4'b0;
      if (n_f) exp_pop[n_g] = 1'b1;
      exp_arb = m_arb; exp_vld = m_vld;
    end
    checks++;
    if (pv !== exp_pop) begin
      errors++;
      $display("FAIL pop at %0t: got %b expected %b", $time, pv, exp_pop);
    end
    checks++;
    if (int'(arbiter) != exp_arb) begin
      errors++;
      $display("FAIL arbiter at %0t: got %0d expected %0d", $time, arbiter, exp_arb);
    end
    checks++;
    if (valid_out !== exp_vld) begin
      errors++;
      $display("FAIL valid_out at %0t: got %b expected %b", $time, valid_out, exp_vld);
    end
    for (int n = 0; n < 4; n++) if (pv[n]) log_q.push_back(n);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, int act, int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  task automatic chk_log(string nm, string expv);
    chk({nm, "_len"}, log_q.size(), expv.len());
    for (int i = 0; i < expv.len() && i < log_q.size(); i++)
      chk($sformatf("%s_g%0d", nm, i), log_q[i], int'(expv[i]) - 48);
  endtask

  task automatic set_w(int a, int b, int c, int d);
    w[0] = 3'(a); w[1] = 3'(b); w[2] = 3'(c); w[3] = 3'(d);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    log_q.delete();
  endtask

  initial begin
    set_w(3, 1, 2, 1);
    empty = 4'h0;
    #1;
    chk("rst_pops", int'({pop3, pop2, pop1, pop0}), 0);
    step();
    chk("rst_arbiter", int'(arbiter), 0);
    chk("rst_valid", int'(valid_out), 0);

    // Basic weighting
    do_reset();
    repeat (8) step();
    chk_log("basic", "00012230");

    // Skip empty channel
    set_w(1, 1, 1, 1); empty = 4'b0010;
    do_reset();
    repeat (6) step();
    chk_log("skip", "023023");

    // Backpressure mid-burst
    set_w(3, 1, 1, 1); empty = 4'h0;
    do_reset();
    repeat (2) step();
    ready_in = 1'b0;
    #1;
    chk("bp_pops", int'({pop3, pop2, pop1, pop0}), 0);
    repeat (2) step();
    chk("bp_valid", int'(valid_out), 0);
    ready_in = 1'b1;
    repeat (2) step();
    chk_log("bp", "0001");

    // Idle then disabled channel
    set_w(1, 1, 1, 1); empty = 4'h0;
    do_reset();
    repeat (2) step();
    empty = 4'hF;
    repeat (3) step();
    chk("idle_arbiter", int'(arbiter), 1);
    chk("idle_valid", int'(valid_out), 0);
    chk_log("idle", "01");
    w[2] = 3'd0; empty = 4'h0;
    log_q.delete();
    repeat (8) step();
    chk_log("disabled", "30130130");

    // Mid-burst empty
    set_w(3, 1, 1, 1); empty = 4'h0;
    do_reset();
    step();
    empty = 4'b0001;
    step();
    chk_log("midempty", "01");

    // Reset during a VC2 burst
    set_w(1, 1, 3, 1); empty = 4'h0;
    do_reset();
    repeat (3) step();
    chk_log("prereset", "012");
    rst = 1'b0;
    #1;
    chk("arst_pops", int'({pop3, pop2, pop1, pop0}), 0);
    chk("arst_arbiter", int'(arbiter), 0);
    chk("arst_valid", int'(valid_out), 0);
    repeat (2) step();
    rst = 1'b1;
    log_q.delete();
    step();
    chk_log("postreset", "0");

    // Random soak against the model
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 16 == 0)
        for (int n = 0; n < 4; n++) w[n] = ($urandom_range(0, 9) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
      for (int n = 0; n < 4; n++) empty[n] = ($urandom_range(0, 9) < 3);
      ready_in = ($urandom_range(0, 99) < 85);
      enb      = ($urandom_range(0, 99) < 92);
      rst      = ($urandom_range(0, 299) != 0);
      step();
    end
    rst = 1'b1;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wrr_scheduler.md
# wrr_scheduler

Weighted round-robin scheduler that drives the `roundrobin` output mux of the virtual-channel path. Watches the four VC FIFO empty flags, issues one pop per cycle to the granted FIFO, and one cycle later presents the matching `arbiter` select plus a `valid` strobe, so the mux output lines up with the FIFO read data. Per-channel weights set how many consecutive grants a channel may take before the pointer rotates.

## Interface
- `WEIGHT_WIDTH`, 3: width of each weight input and of the credit counter.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `enb`  in  1  scheduler enable; when low, no grants are issued and all state holds.
- `ready_in`  in  1  downstream can accept a word this cycle.
- `empty_vchanel0..3`  in  1 each  FIFO empty flags.
- `weight0..3`  in  WEIGHT_WIDTH each  max consecutive grants per channel; 0 disables the channel.
- `pop_vchanel0..3`  out  1 each  combinational pop to FIFO n, at most one high.
- `arbiter`  out  2  registered mux select: 00 = VC0, 01 = VC1, 10 = VC2, 11 = VC3.
- `valid_out`  out  1  registered; `out_wghtd_rndrobin` holds a real word this cycle.

## Operation
- Channel n is eligible when `!empty_vchanelN` and `weightN != 0`.
- State: pointer `cur` (2b), `credit` (WEIGHT_WIDTH), `burst_w` (latched weight), FSM {IDLE, SERVE}.
- The grant decision `g` is made each cycle when `enb && ready_in`:
  - **Continue burst:** in SERVE, if `cur` is eligible and `credit < burst_w`, then `g = cur` and `credit++`.
  - **Rotate:** otherwise `g` is the first eligible channel in the order cur+1, cur+2, cur+3, cur (mod 4). Then `credit = 1` and `burst_w = weight[g]`.
  - **No grant:** if no channel is eligible, there is no grant and the FSM goes to IDLE. `cur` holds; `credit` clears to 0.
- When a grant is made, `pop_vchanel[g]` is asserted in the same cycle, the FSM goes to SERVE and `cur` becomes `g`.
- When `enb` is low or `ready_in` is low, all pops are 0 and `cur`, `credit`, `burst_w` and the FSM hold. A burst resumes where it stopped.
- A weight change only takes effect on the next rotation. The current burst uses `burst_w`.
- If a channel goes empty mid-burst, the scheduler rotates immediately; unused credit is lost.
- If exactly one channel is eligible, the rotation search returns that same channel, so it is served every cycle. Each burst restarts its credit.

## Timing
- Reset (rst = 0, asynchronous):
  - `arbiter` = 00, `valid_out` = 0.
  - All pops = 0 immediately, regardless of inputs.
  - `cur` = 11, so the first search starts at VC0; `credit` = 0, `burst_w` = 0, FSM = IDLE.
- Pop to select latency: 1 cycle. `arbiter <= g` and `valid_out <= 1` on the edge that ends the pop cycle.
- In cycles with no grant, `valid_out <= 0` and `arbiter` holds its last value.
- Throughput: 1 grant per cycle while any channel is eligible and `ready_in` is high.
- Pops depend combinationally on the empty flags. Each FIFO must update its empty flag on the clock edge after a pop, so the next decision sees the true occupancy.

## Structure
- Shared package `wrr_pkg`:
  - Channel codes `VCHANEL0..3` = 2'b00..2'b11.
  - `NUM_VCH` = 4.
  - FSM state codes `IDLE` and `SERVE`.
- Sub-module `wrr_next_channel`: combinational rotating-priority search. Inputs are `cur` and the 4-bit eligible mask; outputs are `found` and `idx`.
- Top level holds the registers, the FSM and the pop decode.

## Test plan
- **Basic weighting:** weights 3,1,2,1, all FIFOs non-empty, `ready_in` = 1. Expected pops VC0,VC0,VC0,VC1,VC2,VC2,VC3,VC0…; `arbiter` repeats the same sequence one cycle later with `valid_out` = 1.
- **Skip empty channel:** weights 1,1,1,1, `empty_vchanel1` = 1. Expected grants 0,2,3,0,2,3; `pop_vchanel1` never asserts.
- **Backpressure:** weights 3,1,1,1, drop `ready_in` for 2 cycles after the 2nd VC0 grant. Pops go to 0 and `valid_out` goes to 0. On release, exactly one more VC0 grant, then VC1.
- **Idle and disabled channel:** all empty gives no pops, `valid_out` = 0 and `arbiter` held. Then set `weight2` = 0 with all non-empty: VC2 is never granted.
- **Mid-burst empty:** VC0 goes empty after its 1st grant with weight 3. The next grant is VC1 in the following cycle.
- **Reset mid-burst:** assert `rst` low during a VC2 burst. Pops drop to 0 immediately and `arbiter` = 00, `valid_out` = 0. After release, the first grant is VC0.
